// File: rtl/rram_core_ctrl_pkg.sv
// Shared types for the RRAM crossbar front end: command opcodes, controller
// states and a helper for sizing the shared cycle timer.
package rram_ctrl_pkg;

   typedef enum logic [1:0] {
      OP_WR_WL = 2'b00,
      OP_WR_BL = 2'b01,
      OP_PROG  = 2'b10,
      OP_MVM   = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_PROG   = 2'b01,
      ST_SETTLE = 2'b10,
      ST_OUT    = 2'b11
   } state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Counter width able to hold the longer of the two timed phases.
   function automatic int timer_width(input int prog_cycles, input int adc_lat);
      return $clog2(max_int(prog_cycles, adc_lat) + 1);
   endfunction

endpackage

// File: rtl/rram_core_ctrl_if.sv
// Host-side command and result handshakes of the RRAM front end; the host
// bridge uses the master view, the controller the slave view.
interface rram_core_ctrl_if #(
   parameter int ADDR_W   = 10,
   parameter int DATA_W   = 32,
   parameter int NUM_ADCS = 32,
   parameter int ADC_BITS = 4,
   parameter int NUM_SEL  = 16
);
   localparam int SEL_W = $clog2(NUM_SEL);

   logic                         cmd_valid_i;
   logic                         cmd_ready_o;
   logic [1:0]                   cmd_op_i;
   logic [ADDR_W-1:0]            cmd_addr_i;
   logic [DATA_W-1:0]            cmd_data_i;

   logic                         res_valid_o;
   logic                         res_ready_i;
   logic [NUM_ADCS*ADC_BITS-1:0] res_data_o;
   logic [SEL_W-1:0]             res_sel_o;
   logic                         res_last_o;

   modport master (
      output cmd_valid_i, cmd_op_i, cmd_addr_i, cmd_data_i, res_ready_i,
      input  cmd_ready_o, res_valid_o, res_data_o, res_sel_o, res_last_o
   );

   modport slave (
      input  cmd_valid_i, cmd_op_i, cmd_addr_i, cmd_data_i, res_ready_i,
      output cmd_ready_o, res_valid_o, res_data_o, res_sel_o, res_last_o
   );
endinterface

// File: rtl/rram_core_ctrl_timer.sv
// Loadable down-counter shared by the WREN pulse and the ADC settle phase;
// done is high during the last counted cycle.
module rram_cycle_timer #(
   parameter int CNT_W = 4
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             done
);
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   assign done = (cnt_q == CNT_W'(1));
endmodule

// File: rtl/rram_core_ctrl.sv
// RRAM crossbar front end: command decode, timed row programming and
// sequenced MVM readout streamed out one ADC group per result beat.
module rram_core_ctrl
   import rram_ctrl_pkg::*;
#(
   parameter int ROWS        = 1024,
   parameter int COLS        = 1024,
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 10,
   parameter int NUM_ADCS    = 32,
   parameter int ADC_BITS    = 4,
   parameter int NUM_SEL     = 16,
   parameter int PROG_CYCLES = 8,
   parameter int ADC_LAT     = 3
) (
   input  logic                         CLK,
   input  logic                         RESET_N,
   rram_core_ctrl_if.slave              bus,
   output logic [ROWS-1:0]              WL_o,
   output logic [COLS-1:0]              BL_o,
   output logic                         WREN_o,
   output logic                         RDEN_o,
   output logic [$clog2(NUM_SEL)-1:0]   ADCSEL_o,
   input  logic [NUM_ADCS*ADC_BITS-1:0] ADC_i,
   output logic                         busy_o,
   output logic                         err_o
);
   localparam int SEL_W    = $clog2(NUM_SEL);
   localparam int RES_W    = NUM_ADCS * ADC_BITS;
   localparam int WL_WORDS = ROWS / DATA_W;
   localparam int BL_WORDS = COLS / DATA_W;
   localparam int TMR_W    = timer_width(PROG_CYCLES, ADC_LAT);

   state_e            state_q, state_d;
   logic [ROWS-1:0]   wl_q;
   logic [COLS-1:0]   bl_q;
   logic [ADDR_W-1:0] prog_row_q;
   logic [SEL_W-1:0]  sel_q;
   logic [RES_W-1:0]  res_data_q;
   logic              err_q;

   logic              cmd_fire, sel_last;
   logic              wl_addr_ok, bl_addr_ok, row_addr_ok;
   logic              wl_we, bl_we, err_set, prog_go, capture, sel_inc, sel_clr;
   logic              tmr_load, tmr_done;
   logic [TMR_W-1:0]  tmr_val;

   assign bus.cmd_ready_o = (state_q == ST_IDLE);
   assign cmd_fire        = bus.cmd_valid_i && bus.cmd_ready_o;
   assign sel_last        = (sel_q == SEL_W'(NUM_SEL - 1));

   assign wl_addr_ok  = 32'(bus.cmd_addr_i) < 32'(WL_WORDS);
   assign bl_addr_ok  = 32'(bus.cmd_addr_i) < 32'(BL_WORDS);
   assign row_addr_ok = 32'(bus.cmd_addr_i) < 32'(ROWS);

   rram_cycle_timer #(.CNT_W(TMR_W)) u_timer (
      .CLK      (CLK),
      .RESET_N  (RESET_N),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   always_ff @(posedge CLK or negedge RESET_N) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      if (!RESET_N) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path infers a latch.
      state_d  = state_q;
      wl_we    = 1'b0;
      bl_we    = 1'b0;
      err_set  = 1'b0;
      prog_go  = 1'b0;
      capture  = 1'b0;
      sel_inc  = 1'b0;
      sel_clr  = 1'b0;
      tmr_load = 1'b0;
      tmr_val  = '0;
      case (state_q)
         ST_IDLE: begin
            if (cmd_fire) begin
               case (op_e'(bus.cmd_op_i))
                  OP_WR_WL: begin
                     wl_we   = wl_addr_ok;
                     err_set = !wl_addr_ok;
                  end
                  OP_WR_BL: begin
                     bl_we   = bl_addr_ok;
                     err_set = !bl_addr_ok;
                  end
                  OP_PROG: begin
                     if (row_addr_ok) begin
                        prog_go  = 1'b1;
                        tmr_load = 1'b1;
                        tmr_val  = TMR_W'(PROG_CYCLES);
                        state_d  = ST_PROG;
                     end else begin
                        err_set = 1'b1;
                     end
                  end
                  OP_MVM: begin
                     tmr_load = 1'b1;
                     tmr_val  = TMR_W'(ADC_LAT);
                     state_d  = ST_SETTLE;
                  end
                  default: ;
               endcase
            end
         end
         ST_PROG: begin
            if (tmr_done) state_d = ST_IDLE;
         end
         ST_SETTLE: begin
            if (tmr_done) begin
               capture = 1'b1;
               state_d = ST_OUT;
            end
         end
         ST_OUT: begin
            if (bus.res_ready_i) begin
               if (sel_last) begin
                  sel_clr = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  sel_inc  = 1'b1;
                  tmr_load = 1'b1;
                  tmr_val  = TMR_W'(ADC_LAT);
                  state_d  = ST_SETTLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      // NOTE: the WL/BL stores are flip-flops rather than a RAM, so they can and do take the async clear.
      if (!RESET_N) begin
         wl_q       <= '0;
         bl_q       <= '0;
         prog_row_q <= '0;
         sel_q      <= '0;
         res_data_q <= '0;
         err_q      <= 1'b0;
      end else begin
         for (int w = 0; w < WL_WORDS; w++) begin
            if (wl_we && bus.cmd_addr_i == ADDR_W'(w)) wl_q[w*DATA_W +: DATA_W] <= bus.cmd_data_i;
         end
         for (int w = 0; w < BL_WORDS; w++) begin
            if (bl_we && bus.cmd_addr_i == ADDR_W'(w)) bl_q[w*DATA_W +: DATA_W] <= bus.cmd_data_i;
         end
         if (prog_go) prog_row_q <= bus.cmd_addr_i;
         if (sel_clr)      sel_q <= '0;
         else if (sel_inc) sel_q <= sel_q + SEL_W'(1);
         if (capture) res_data_q <= ADC_i;
         if (err_set) err_q <= 1'b1;
      end
   end

   // During PROG only the addressed row is driven; the stored WL word is untouched.
   assign WL_o     = (state_q == ST_PROG) ? (ROWS'(1) << prog_row_q) : wl_q;
   assign BL_o     = bl_q;
   assign WREN_o   = (state_q == ST_PROG);
   assign RDEN_o   = (state_q == ST_SETTLE) || (state_q == ST_OUT);
   assign ADCSEL_o = sel_q;
   assign busy_o   = (state_q != ST_IDLE);
   assign err_o    = err_q;

   assign bus.res_valid_o = (state_q == ST_OUT);
   assign bus.res_data_o  = res_data_q;
   assign bus.res_sel_o   = sel_q;
   assign bus.res_last_o  = (state_q == ST_OUT) && sel_last;
endmodule

// File: tb/tb_rram_core_ctrl.sv
// Bench for rram_core_ctrl: directed commands, with expected result beats
// queued at issue time and checked by an independent monitor.
module tb_rram_core_ctrl;
   import rram_ctrl_pkg::*;

   localparam int ROWS        = 1024;
   localparam int COLS        = 1024;
   localparam int DATA_W      = 32;
   localparam int ADDR_W      = 10;
   localparam int NUM_ADCS    = 32;
   localparam int ADC_BITS    = 4;
   localparam int NUM_SEL     = 16;
   localparam int PROG_CYCLES = 8;
   localparam int ADC_LAT     = 3;
   localparam int SEL_W       = 4;
   localparam int RES_W       = NUM_ADCS * ADC_BITS;
   localparam int CW          = 1024;

   logic CLK = 1'b0;
   logic RESET_N = 1'b0;
   always #5 CLK = ~CLK;

   rram_core_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_ADCS(NUM_ADCS),
                       .ADC_BITS(ADC_BITS), .NUM_SEL(NUM_SEL)) bus ();

   logic [ROWS-1:0]  WL_o;
   logic [COLS-1:0]  BL_o;
   logic             WREN_o, RDEN_o, busy_o, err_o;
   logic [SEL_W-1:0] ADCSEL_o;
   logic [RES_W-1:0] ADC_i;

   rram_core_ctrl #(
      .ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_ADCS(NUM_ADCS),
      .ADC_BITS(ADC_BITS), .NUM_SEL(NUM_SEL), .PROG_CYCLES(PROG_CYCLES), .ADC_LAT(ADC_LAT)
   ) dut (
      .CLK(CLK), .RESET_N(RESET_N), .bus(bus),
      .WL_o(WL_o), .BL_o(BL_o), .WREN_o(WREN_o), .RDEN_o(RDEN_o),
      .ADCSEL_o(ADCSEL_o), .ADC_i(ADC_i), .busy_o(busy_o), .err_o(err_o)
   );

   // Crossbar model: every nibble reports the selected group, settling two edges after ADCSEL moves.
   logic [SEL_W-1:0] sel_d1, sel_d2;
   always @(posedge CLK) begin
      sel_d1 <= ADCSEL_o;
      sel_d2 <= sel_d1;
   end
   assign ADC_i = {NUM_ADCS{sel_d2}};

   typedef struct {
      logic [RES_W-1:0] data;
      logic [SEL_W-1:0] sel;
      logic             last;
   } beat_t;

   beat_t exp_q[$];
   int total = 0;
   int bad   = 0;
   logic [ROWS-1:0] exp_wl;
   logic [COLS-1:0] exp_bl;
   logic [ROWS-1:0] one_hot;

   task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      int first;
      total++;
      if (act !== exp) begin
         bad++;
         first = -1;
         for (int i = CW - 1; i >= 0; i--) if (act[i] !== exp[i]) first = i;
         $display("FAIL %s: got %0h expected %0h (low 128 bits, first diff at bit %0d)",
                  name, act[127:0], exp[127:0], first);
      end
   endtask

   task automatic timeout_fail(input string name);
      total++;
      bad++;
      $display("FAIL %s: got timeout expected DUT event", name);
   endtask

   task automatic push_beats(input int n);
      beat_t b;
      logic [SEL_W-1:0] s4;
      for (int s = 0; s < n; s++) begin
         s4     = SEL_W'(s);
         b.data = {NUM_ADCS{s4}};
         b.sel  = s4;
         b.last = (s == NUM_SEL - 1);
         exp_q.push_back(b);
      end
   endtask

   task automatic send_cmd(input op_e op, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
      int n;
      @(negedge CLK);
      bus.cmd_valid_i = 1'b1;
      bus.cmd_op_i    = op;
      bus.cmd_addr_i  = addr;
      bus.cmd_data_i  = data;
      n = 0;
      while (!bus.cmd_ready_o && n < 500) begin
         @(negedge CLK);
         n++;
      end
      if (n >= 500) timeout_fail("cmd_accept");
      @(posedge CLK);
      #1 bus.cmd_valid_i = 1'b0;
   endtask

   // Monitor: every presented beat is compared with the queue head, popped on handshake.
   initial begin
      beat_t h;
      forever begin
         @(negedge CLK);
         if (RESET_N && bus.res_valid_o) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_beat: got sel=%0d expected no beat", bus.res_sel_o);
            end else begin
               h = exp_q[0];
               check("beat_sel",  CW'(bus.res_sel_o),  CW'(h.sel));
               check("beat_data", CW'(bus.res_data_o), CW'(h.data));
               check("beat_last", CW'(bus.res_last_o), CW'(h.last));
               if (bus.res_ready_i) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got time limit expected test end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cyc;
      int n;
      bus.cmd_valid_i = 1'b0;
      bus.cmd_op_i    = 2'b00;
      bus.cmd_addr_i  = '0;
      bus.cmd_data_i  = '0;
      bus.res_ready_i = 1'b1;
      exp_wl = '0;
      exp_bl = '0;

      repeat (3) @(negedge CLK);
      RESET_N = 1'b1;
      @(negedge CLK);
      check("rst_cmd_ready", CW'(bus.cmd_ready_o), CW'(1));
      check("rst_res_valid", CW'(bus.res_valid_o), CW'(0));
      check("rst_res_data",  CW'(bus.res_data_o),  CW'(0));
      check("rst_res_sel",   CW'(bus.res_sel_o),   CW'(0));
      check("rst_res_last",  CW'(bus.res_last_o),  CW'(0));
      check("rst_wren",      CW'(WREN_o),          CW'(0));
      check("rst_rden",      CW'(RDEN_o),          CW'(0));
      check("rst_adcsel",    CW'(ADCSEL_o),        CW'(0));
      check("rst_busy",      CW'(busy_o),          CW'(0));
      check("rst_err",       CW'(err_o),           CW'(0));
      check("rst_wl",        CW'(WL_o),            CW'(0));
      check("rst_bl",        CW'(BL_o),            CW'(0));

      // WL word write lands in bits 127:96
      send_cmd(OP_WR_WL, 10'd3, 32'hDEAD_BEEF);
      exp_wl[127:96] = 32'hDEAD_BEEF;
      @(negedge CLK);
      check("wr_wl_word3", CW'(WL_o), CW'(exp_wl));
      check("wr_wl_err",   CW'(err_o), CW'(0));

      // out-of-range BL write is dropped and sets the sticky error
      send_cmd(OP_WR_BL, 10'd32, 32'h1234_5678);
      @(negedge CLK);
      check("wr_bl_oor_data", CW'(BL_o), CW'(exp_bl));
      check("wr_bl_oor_err",  CW'(err_o), CW'(1));
      send_cmd(OP_WR_BL, 10'd1, 32'hA5A5_0F0F);
      exp_bl[63:32] = 32'hA5A5_0F0F;
      @(negedge CLK);
      check("wr_bl_word1", CW'(BL_o), CW'(exp_bl));
      check("err_sticky",  CW'(err_o), CW'(1));

      // PROG row 5: one-hot WL with WREN for exactly PROG_CYCLES cycles
      send_cmd(OP_WR_WL, 10'd0, 32'h0000_FFFF);
      exp_wl[31:0] = 32'h0000_FFFF;
      @(negedge CLK);
      check("wr_wl_word0", CW'(WL_o), CW'(exp_wl));
      one_hot = '0;
      one_hot[5] = 1'b1;
      send_cmd(OP_PROG, 10'd5, 32'h0);
      for (int i = 0; i < PROG_CYCLES; i++) begin
         @(negedge CLK);
         check("prog_wren",  CW'(WREN_o), CW'(1));
         check("prog_wl",    CW'(WL_o),   CW'(one_hot));
         check("prog_ready", CW'(bus.cmd_ready_o), CW'(0));
         check("prog_bl",    CW'(BL_o),   CW'(exp_bl));
      end
      @(negedge CLK);
      check("prog_end_wren",  CW'(WREN_o), CW'(0));
      check("prog_end_wl",    CW'(WL_o),   CW'(exp_wl));
      check("prog_end_ready", CW'(bus.cmd_ready_o), CW'(1));

      // full MVM with the result sink always ready
      push_beats(NUM_SEL);
      send_cmd(OP_MVM, 10'd0, 32'h0);
      cyc = 0;
      @(negedge CLK);
      while (busy_o && cyc < 300) begin
         cyc++;
         @(negedge CLK);
      end
      check("mvm_cycles",      CW'(cyc), CW'(NUM_SEL * (ADC_LAT + 1)));
      check("mvm_rden_after",  CW'(RDEN_o), CW'(0));
      check("mvm_all_beats",   CW'(exp_q.size()), CW'(0));

      // MVM with the sink stalled for 10 cycles on beat 2
      push_beats(NUM_SEL);
      send_cmd(OP_MVM, 10'd0, 32'h0);
      n = 0;
      @(negedge CLK);
      while (bus.res_sel_o != SEL_W'(2) && n < 300) begin
         n++;
         @(negedge CLK);
      end
      if (n >= 300) timeout_fail("stall_reach_beat2");
      bus.res_ready_i = 1'b0;
      n = 0;
      while (!bus.res_valid_o && n < 50) begin
         n++;
         @(negedge CLK);
      end
      if (n >= 50) timeout_fail("stall_beat2_valid");
      repeat (10) @(negedge CLK);
      check("stall_held_sel", CW'(bus.res_sel_o), CW'(2));
      @(posedge CLK);
      #1 bus.res_ready_i = 1'b1;
      n = 0;
      @(negedge CLK);
      while (busy_o && n < 300) begin
         n++;
         @(negedge CLK);
      end
      if (n >= 300) timeout_fail("stall_mvm_done");
      check("stall_all_beats", CW'(exp_q.size()), CW'(0));

      // asynchronous reset during SETTLE of beat 7
      push_beats(7);
      send_cmd(OP_MVM, 10'd0, 32'h0);
      n = 0;
      @(negedge CLK);
      while (!(RDEN_o && !bus.res_valid_o && bus.res_sel_o == SEL_W'(7)) && n < 300) begin
         n++;
         @(negedge CLK);
      end
      if (n >= 300) timeout_fail("rst_reach_beat7");
      #2 RESET_N = 1'b0;
      #1;
      check("arst_rden",      CW'(RDEN_o), CW'(0));
      check("arst_res_valid", CW'(bus.res_valid_o), CW'(0));
      check("arst_wl",        CW'(WL_o), CW'(0));
      check("arst_bl",        CW'(BL_o), CW'(0));
      check("arst_err",       CW'(err_o), CW'(0));
      check("arst_beats_0_6", CW'(exp_q.size()), CW'(0));
      @(negedge CLK);
      RESET_N = 1'b1;
      @(negedge CLK);
      check("arst_cmd_ready", CW'(bus.cmd_ready_o), CW'(1));
      check("arst_busy",      CW'(busy_o), CW'(0));
      check("arst_adcsel",    CW'(ADCSEL_o), CW'(0));

      repeat (2) @(negedge CLK);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/rram_core_ctrl.md
Name: rram_core_ctrl

Overview:
Parametrised next-generation front end for the RRAM crossbar, on a single clock. It accepts commands over a valid/ready handshake and has four commands: load a WL word, load a BL word, program one row, and run an MVM. It sequences WREN/RDEN/ADCSEL with programmable pulse and settle times and streams ADC results out over a second valid/ready handshake, one ADCSEL group per beat. It sits between the host/bus bridge and the crossbar macro, and adds timed programming, sequenced ADC readout and error reporting.

Parameters:
ROWS, 1024, number of wordlines; multiple of DATA_W
COLS, 1024, number of bitlines; multiple of DATA_W
DATA_W, 32, command data word width
ADDR_W, 10, command address width; must be >= clog2(max(ROWS, COLS/DATA_W))
NUM_ADCS, 32, ADC channels sampled per ADCSEL group
ADC_BITS, 4, bits per ADC result
NUM_SEL, 16, ADCSEL groups per MVM; SEL_W = clog2(NUM_SEL)
PROG_CYCLES, 8, WREN pulse length in cycles (>= 1)
ADC_LAT, 3, cycles from ADCSEL change to valid ADC_i (>= 1)

Ports:
CLK  input  1  single clock; all logic on rising edge
RESET_N  input  1  asynchronous active-low reset
cmd_valid_i  input  1  command valid
cmd_ready_o  output  1  command ready; high only in IDLE
cmd_op_i  input  2  00 WR_WL, 01 WR_BL, 10 PROG, 11 MVM
cmd_addr_i  input  ADDR_W  word index for WR_WL/WR_BL; row index for PROG
cmd_data_i  input  DATA_W  write data for WR_WL/WR_BL
res_valid_o  output  1  result beat valid
res_ready_i  input  1  result beat accepted
res_data_o  output  NUM_ADCS*ADC_BITS  captured ADC_i for one group
res_sel_o  output  SEL_W  group index of the current beat
res_last_o  output  1  high on the beat for group NUM_SEL-1
WL_o  output  ROWS  wordline drive to the crossbar
BL_o  output  COLS  bitline drive to the crossbar
WREN_o  output  1  program enable
RDEN_o  output  1  read enable
ADCSEL_o  output  SEL_W  ADC group select
ADC_i  input  NUM_ADCS*ADC_BITS  ADC results from the crossbar
busy_o  output  1  high when state != IDLE
err_o  output  1  sticky out-of-range address flag

Behaviour:
- Reset (asynchronous, RESET_N low): WL register and BL register clear to 0; state goes to IDLE. Reset values: cmd_ready_o=1 once RESET_N deasserts; res_valid_o=0, res_data_o=0, res_sel_o=0, res_last_o=0, WREN_o=0, RDEN_o=0, ADCSEL_o=0, busy_o=0, err_o=0.
- Reset mid-operation aborts immediately: WREN_o and RDEN_o drop, and any pending result is lost.
- A command is accepted on the cycle where cmd_valid_i && cmd_ready_o. cmd_ready_o = (state == IDLE).
- WR_WL: WL[addr*DATA_W +: DATA_W] <= data, visible on WL_o the next cycle; state stays IDLE. If addr >= ROWS/DATA_W: no write, err_o <= 1.
- WR_BL: same as WR_WL on BL, with limit COLS/DATA_W.
- PROG: if addr >= ROWS, set err_o and stay in IDLE. Otherwise go to PROG. In PROG, WL_o = one-hot(addr) and the stored WL register is not modified; WREN_o=1 for exactly PROG_CYCLES cycles; BL_o = BL register. Then return to IDLE and WL_o shows the stored WL register again on the next cycle.
- MVM sequence:
  - Go to SETTLE with sel=0: RDEN_o=1, ADCSEL_o=sel, counter counts ADC_LAT cycles.
  - On counter expiry, capture ADC_i into res_data_o and go to OUT.
  - OUT: res_valid_o=1, res_sel_o=sel, res_last_o=(sel==NUM_SEL-1). res_data_o, res_sel_o and res_last_o are held stable until res_ready_i.
  - On handshake, if not last: sel+1, back to SETTLE with res_valid_o=0. If last: RDEN_o=0, go to IDLE.
  - RDEN_o stays high for the whole MVM.
- States: IDLE, PROG, SETTLE, OUT. No other transitions. While busy, commands are stalled, not dropped.
- err_o clears only on reset.
- Minimum MVM duration, with res_ready_i held high: NUM_SEL*(ADC_LAT+1) cycles from acceptance to return to IDLE.

Decomposition:
- Package rram_ctrl_pkg: op_e enum (WR_WL, WR_BL, PROG, MVM); state_e enum (IDLE, PROG, SETTLE, OUT).
- One sub-module, rram_cycle_timer: loadable down-counter with a done pulse, shared by PROG (loaded with PROG_CYCLES) and SETTLE (loaded with ADC_LAT).

Test Plan:
- WR_WL addr=3, data=0xDEADBEEF -> WL_o[127:96]=0xDEADBEEF one cycle after acceptance; all other WL_o bits 0; err_o=0.
- WR_BL addr=32 (out of range with COLS=1024) -> BL_o unchanged, err_o=1 and stays 1; a following valid WR_BL still writes.
- WL word 0 = 0xFFFF, then PROG addr=5 -> WL_o=1<<5 for exactly 8 cycles with WREN_o high; afterwards WL_o[31:0]=0x0000FFFF; cmd_ready_o low throughout PROG.
- MVM, res_ready_i=1, ADC_i driven as a function of ADCSEL_o (all nibbles = sel) -> 16 beats, res_sel_o 0..15, data nibbles equal to sel, res_last_o only on beat 15, 64 cycles total, then RDEN_o=0.
- MVM with res_ready_i low for 10 cycles on beat 2 -> res_valid_o, res_data_o and res_sel_o stay stable; no beat is skipped or duplicated.
- RESET_N pulsed low during SETTLE of beat 7 -> asynchronous clear; RDEN_o=0, res_valid_o=0, WL_o=0, cmd_ready_o=1 after release.
